mips_cpu_muldiv: RTL and testbench

Multi-cycle, parametrised multiply/divide unit with architectural HI/LO registers, consuming the 3-bit `toMult` operation code produced by the ALU control decoder. MULT/MULTU/DIV/DIVU run iteratively over several cycles while MTHI/MTLO/MFHI/MFLO complete immediately. A valid/ready handshake stalls the pipeline on HI/LO hazards, and a flush input cancels in-flight work on exceptions or branches.

---
 rtl/mips_cpu_muldiv.sv | 181 ++++++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_muldiv.sv
// Iterative MIPS multiply/divide unit with HI/LO; retires BITS_PER_CYCLE bits per BUSY cycle.
// Define MIPS_MULDIV_EARLY_OUT_EN to let multiplies leave BUSY once the multiplier is exhausted.
module mips_cpu_muldiv #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   input  logic             flush,
   output logic [WIDTH-1:0] rd_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);
   localparam int N  = WIDTH / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d, rs_q, rs_d, hi_q, hi_d, lo_q, lo_d;
   logic               is_div_q, is_div_d, neg_q, neg_d, neg_rem_q, neg_rem_d;
   logic               div0_q, div0_d, done_q, done_d;

   logic               accept;
   logic [WIDTH-1:0]   a_mag, b_mag, quo_t;
   logic [WIDTH:0]     rem_t;
   logic [2*WIDTH-1:0] sum_t, prod_t;

   assign op_ready = (state_q == S_IDLE) && !flush;
   assign accept   = op_valid && op_ready;
   // op[1] marks the signed variants (MULT, DIV)
   assign a_mag    = (op[1] && rs[WIDTH-1]) ? -rs : rs;
   assign b_mag    = (op[1] && rt[WIDTH-1]) ? -rt : rt;
   assign hi       = hi_q;
   assign lo       = lo_q;
   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;

   always_comb begin
      rd_data = '0;
      if (accept && op == 3'b110) rd_data = hi_q;
      else if (accept && op == 3'b111) rd_data = lo_q;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      rs_d      = rs_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      done_d    = 1'b0;
      rem_t     = '0;
      quo_t     = '0;
      sum_t     = '0;
      prod_t    = '0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (op[2]) begin
                  if (op[1:0] == 2'b00) hi_d = rs;
                  else if (op[1:0] == 2'b01) lo_d = rs;
               end else begin
                  state_d   = S_BUSY;
                  cnt_d     = CW'(N);
                  is_div_d  = !op[0];
                  neg_d     = op[1] && (rs[WIDTH-1] ^ rt[WIDTH-1]);
                  neg_rem_d = op[1] && rs[WIDTH-1];
                  div0_d    = (rt == '0);
                  rs_d      = rs;
                  acc_d     = '0;
                  mcand_d   = {{WIDTH{1'b0}}, (op[0] ? a_mag : b_mag)};
                  mplier_d  = op[0] ? b_mag : a_mag;
               end
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q - CW'(1);
            if (is_div_q) begin
               // restoring division: acc low half is the remainder, mplier shifts dividend out / quotient in
               rem_t = {1'b0, acc_q[WIDTH-1:0]};
               quo_t = mplier_q;
               for (int j = 0; j < BITS_PER_CYCLE; j++) begin
                  rem_t = {rem_t[WIDTH-1:0], quo_t[WIDTH-1]};
                  quo_t = quo_t << 1;
                  if (rem_t >= {1'b0, mcand_q[WIDTH-1:0]}) begin
                     rem_t    = rem_t - {1'b0, mcand_q[WIDTH-1:0]};
                     quo_t[0] = 1'b1;
                  end
               end
               acc_d    = {{WIDTH{1'b0}}, rem_t[WIDTH-1:0]};
               mplier_d = quo_t;
            end else begin
               sum_t = acc_q;
               for (int j = 0; j < BITS_PER_CYCLE; j++) begin
                  if (mplier_q[j]) sum_t = sum_t + (mcand_q << j);
               end
               acc_d    = sum_t;
               mcand_d  = mcand_q << BITS_PER_CYCLE;
               mplier_d = mplier_q >> BITS_PER_CYCLE;
            end
            if (cnt_q == CW'(1)) state_d = S_FIX;
`ifdef MIPS_MULDIV_EARLY_OUT_EN
            if (!is_div_q && (mplier_q >> BITS_PER_CYCLE) == '0) state_d = S_FIX;
`endif
         end
         S_FIX: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (is_div_q) begin
               if (div0_q) begin
                  hi_d = rs_q;
                  lo_d = '1;
               end else begin
                  // most-negative / -1 falls out naturally: negating 2^(W-1) wraps to itself
                  lo_d = neg_q ? -mplier_q : mplier_q;
                  hi_d = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
               end
            end else begin
               prod_t = neg_q ? -acc_q : acc_q;
               hi_d   = prod_t[2*WIDTH-1:WIDTH];
               lo_d   = prod_t[WIDTH-1:0];
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (flush && state_q != S_IDLE) begin
         state_d = S_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         rs_q      <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         rs_q      <= rs_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
         done_q    <= done_d;
      end
   end
endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Bench for mips_cpu_muldiv: directed table, stall/flush/reset sequences, and random sweeps
// against a behavioural model on a 32/1 instance plus 16/32-bit, 2/4-bits-per-cycle instances.
module tb_mips_cpu_muldiv;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        reset_n, op_valid, op_ready, flush, busy, done;
   logic [2:0]  op;
   logic [31:0] rs, rt, rd_data, hi, lo;

   mips_cpu_muldiv #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
      .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready), .op(op),
      .rs(rs), .rt(rt), .flush(flush), .rd_data(rd_data), .hi(hi), .lo(lo),
      .busy(busy), .done(done));

   logic        sw_reset_n, sw_valid, sw_flush;
   logic [2:0]  sw_op;
   logic [31:0] sw_rs, sw_rt;
   logic        sw_ready [4];
   logic        sw_busy  [4];
   logic        sw_done  [4];
   logic [31:0] sw_hi [4];
   logic [31:0] sw_lo [4];
   logic [31:0] sw_rd [4];

   for (genvar g = 0; g < 4; g++) begin : g_sw
      localparam int W = (g < 2) ? 16 : 32;
      localparam int B = (g % 2 == 0) ? 2 : 4;
      logic [W-1:0] hi_w, lo_w, rd_w;
      mips_cpu_muldiv #(.WIDTH(W), .BITS_PER_CYCLE(B)) u (
         .clk(clk), .reset_n(sw_reset_n), .op_valid(sw_valid), .op_ready(sw_ready[g]),
         .op(sw_op), .rs(sw_rs[W-1:0]), .rt(sw_rt[W-1:0]), .flush(sw_flush),
         .rd_data(rd_w), .hi(hi_w), .lo(lo_w), .busy(sw_busy[g]), .done(sw_done[g]));
      assign sw_hi[g] = 32'(hi_w);
      assign sw_lo[g] = 32'(lo_w);
      assign sw_rd[g] = 32'(rd_w);
   end

   int nchk = 0;
   int nerr = 0;

   typedef struct {
      int          inst;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b, hi, lo;
      string       name;
   } vec_t;
   vec_t vt [11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      nchk++;
      nerr++;
      $display("FAIL %s: got no response, required a response", name);
   endtask

   task automatic sb_drop(input int inst);
      for (int k = 0; k < sb_q.size(); k++)
         if (sb_q[k].inst == inst) begin
            sb_q.delete(k);
            break;
         end
   endtask

   task automatic sb_check(input int inst, input string name, input logic [31:0] ghi, input logic [31:0] glo);
      int idx = -1;
      for (int k = 0; k < sb_q.size(); k++)
         if (sb_q[k].inst == inst) begin
            idx = k;
            break;
         end
      if (idx < 0) begin
         fail({name, "_unexpected_done"});
      end else begin
         check({name, "_hi"}, 64'(ghi), 64'(sb_q[idx].hi));
         check({name, "_lo"}, 64'(glo), 64'(sb_q[idx].lo));
         sb_q.delete(idx);
      end
   endtask

   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a_in,
                                         input logic [31:0] b_in, input int w);
      logic [63:0] mask, ua, ub, p, rh, rl;
      longint sa, sb;
      mask = (64'd1 << w) - 64'd1;
      ua   = 64'(a_in) & mask;
      ub   = 64'(b_in) & mask;
      sa   = a_in[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
      sb   = b_in[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
      rh   = '0;
      rl   = '0;
      case (o)
         3'b011: begin p = 64'(sa * sb); rh = (p >> w) & mask; rl = p & mask; end
         3'b001: begin p = ua * ub;      rh = (p >> w) & mask; rl = p & mask; end
         3'b010: begin
            if (ub == 0) begin rh = ua; rl = mask; end
            else if (sa == -(longint'(1) << (w - 1)) && sb == -1) begin
               rh = 0; rl = 64'd1 << (w - 1);
            end else begin
               rl = 64'(sa / sb) & mask; rh = 64'(sa % sb) & mask;
            end
         end
         default: begin
            if (ub == 0) begin rh = ua; rl = mask; end
            else begin rl = ua / ub; rh = ua % ub; end
         end
      endcase
      return {rh[31:0], rl[31:0]};
   endfunction

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 8))
         0: return 32'h0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'h1;
         4: return 32'h00008000;
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [2:0] rnd_op();
      case ($urandom_range(0, 3))
         0: return 3'b011;
         1: return 3'b001;
         2: return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   // entered just after a rising edge; returns just after the accepting edge
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output int acc);
      acc = -1;
      op = o; rs = a; rt = b; op_valid = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (op_ready) begin
            acc = cyc;
            break;
         end
      end
      if (acc < 0) fail("issue_timeout");
      @(posedge clk); #1;
      op_valid = 1'b0;
   endtask

   task automatic wait_done(input string name, input int acc, input int lat);
      int dc = -1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (done) begin
            dc = cyc;
            break;
         end
      end
      if (dc < 0) begin
         fail({name, "_done_timeout"});
         sb_drop(0);
      end else begin
         sb_check(0, name, hi, lo);
         if (lat >= 0) check({name, "_latency"}, 64'(dc - acc), 64'(lat));
         @(negedge clk);
         check({name, "_done_single"}, 64'(done), 64'd0);
      end
      @(posedge clk); #1;
   endtask

   function automatic int mul_lat(input logic [2:0] o, input int full);
`ifdef MIPS_MULDIV_EARLY_OUT_EN
      return o[0] ? -1 : full;
`else
      return (o[0] || !o[0]) ? full : full;
`endif
   endfunction

   initial begin
      int          acc, dc, bad, cnt, rdy;
      logic [63:0] e;
      logic [2:0]  o;
      logic [31:0] a, b;
      logic [3:0]  got;

      vt[0]  = '{3'b011, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, "mult_m1x2"};
      vt[1]  = '{3'b001, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, "multu_ffx2"};
      vt[2]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7d2"};
      vt[3]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"};
      vt[4]  = '{3'b000, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, "divu_by0"};
      vt[5]  = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7dm2"};
      vt[6]  = '{3'b000, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, "divu_100d7"};
      vt[7]  = '{3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_min2"};
      vt[8]  = '{3'b010, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, "div_by0"};
      vt[9]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
      vt[10] = '{3'b000, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, "divu_ff_d16"};

      reset_n = 1'b0; op_valid = 1'b0; op = 3'b000; rs = '0; rt = '0; flush = 1'b0;
      sw_reset_n = 1'b0; sw_valid = 1'b0; sw_op = 3'b000; sw_rs = '0; sw_rt = '0; sw_flush = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_rd_data", 64'(rd_data), 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1; sw_reset_n = 1'b1;
      @(negedge clk);
      check("rst_op_ready", 64'(op_ready), 64'd1);
      @(posedge clk); #1;

      issue(3'b100, 32'h12345678, 32'h0, acc);
      @(negedge clk);
      check("mthi_hi", 64'(hi), 64'h12345678);
      check("mthi_lo", 64'(lo), 64'd0);
      check("mthi_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      op = 3'b110; op_valid = 1'b1;
      @(negedge clk);
      check("mfhi_ready", 64'(op_ready), 64'd1);
      check("mfhi_rd_data", 64'(rd_data), 64'h12345678);
      @(posedge clk); #1;
      op_valid = 1'b0;
      @(negedge clk);
      check("rd_data_idle", 64'(rd_data), 64'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) begin
         sb_q.push_back('{0, vt[i].hi, vt[i].lo});
         issue(vt[i].op, vt[i].a, vt[i].b, acc);
         wait_done(vt[i].name, acc, vt[i].op[0] ? mul_lat(vt[i].op, 34) : 34);
      end

      // MFLO held behind a MULT must stall until the done cycle, then see the new LO
      sb_q.push_back('{0, 32'h0, 32'd15});
      issue(3'b011, 32'd3, 32'd5, acc);
      op = 3'b111; rs = '0; op_valid = 1'b1;
      bad = 0; dc = -1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (done) begin
            dc = cyc;
            break;
         end else if (op_ready) bad++;
      end
      check("stall_ready_low", 64'(bad), 64'd0);
      if (dc < 0) begin
         fail("stall_done_timeout");
         sb_drop(0);
      end else begin
         check("stall_ready_in_done", 64'(op_ready), 64'd1);
         check("stall_mflo_data", 64'(rd_data), 64'd15);
         sb_check(0, "stall_mult", hi, lo);
         if (mul_lat(3'b011, 34) >= 0) check("stall_latency", 64'(dc - acc), 64'd34);
      end
      @(posedge clk); #1;
      op_valid = 1'b0;
      @(negedge clk);
      check("stall_done_single", 64'(done), 64'd0);
      check("stall_mflo_no_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;

      issue(3'b100, 32'hAAAA0000, 32'h0, acc);
      issue(3'b101, 32'h0000BBBB, 32'h0, acc);
      issue(3'b010, 32'd100, 32'd3, acc);
      for (int k = 0; k < 20 && cyc != acc + 10; k++) begin
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(negedge clk);
      check("flush_busy_c10", 64'(busy), 64'd1);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check("flush_busy_c11", 64'(busy), 64'd0);
      check("flush_hi_kept", 64'(hi), 64'hAAAA0000);
      check("flush_lo_kept", 64'(lo), 64'h0000BBBB);
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         if (done) cnt++;
         @(negedge clk);
      end
      check("flush_no_done", 64'(cnt), 64'd0);
      @(posedge clk); #1;
      flush = 1'b1; op = 3'b110; op_valid = 1'b1;
      @(negedge clk);
      check("flush_idle_ready", 64'(op_ready), 64'd0);
      check("flush_idle_rd_data", 64'(rd_data), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0; op_valid = 1'b0;

      issue(3'b000, 32'd1000, 32'd7, acc);
      for (int k = 0; k < 20 && cyc != acc + 10; k++) begin
         @(posedge clk); #1;
      end
      reset_n = 1'b0;
      #1;
      check("rstmid_hi", 64'(hi), 64'd0);
      check("rstmid_lo", 64'(lo), 64'd0);
      check("rstmid_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      check("rstmid_ready", 64'(op_ready), 64'd1);
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         if (done) cnt++;
         @(negedge clk);
      end
      check("rstmid_no_done", 64'(cnt), 64'd0);
      @(posedge clk); #1;

`ifdef MIPS_MULDIV_EARLY_OUT_EN
      sb_q.push_back('{0, 32'h0, 32'h1234});
      issue(3'b001, 32'h1234, 32'h1, acc);
      wait_done("early_rt1", acc, 3);
      sb_q.push_back('{0, 32'h0, 32'h0});
      issue(3'b011, 32'h55, 32'h0, acc);
      wait_done("early_rt0", acc, 3);
`else
      sb_q.push_back('{0, 32'h0, 32'h1234});
      issue(3'b001, 32'h1234, 32'h1, acc);
      wait_done("early_rt1", acc, 34);
      sb_q.push_back('{0, 32'h0, 32'h0});
      issue(3'b011, 32'h55, 32'h0, acc);
      wait_done("early_rt0", acc, 34);
`endif
      sb_q.push_back('{0, 32'h0, 32'h99});
      issue(3'b000, 32'h99, 32'h1, acc);
      wait_done("divu_rt1", acc, 34);

      for (int i = 0; i < 40; i++) begin
         o = rnd_op(); a = rnd_val(); b = rnd_val();
         e = model(o, a, b, 32);
         sb_q.push_back('{0, e[63:32], e[31:0]});
         issue(o, a, b, acc);
         wait_done("rand32", acc, o[0] ? mul_lat(o, 34) : 34);
      end

      for (int i = 0; i < 30; i++) begin
         o = rnd_op(); a = rnd_val(); b = rnd_val();
         for (int g = 0; g < 4; g++) begin
            e = model(o, a, b, (g < 2) ? 16 : 32);
            sb_q.push_back('{g + 1, e[63:32], e[31:0]});
         end
         sw_op = o; sw_rs = a; sw_rt = b; sw_valid = 1'b1;
         @(negedge clk);
         rdy = 0;
         for (int g = 0; g < 4; g++) if (sw_ready[g]) rdy++;
         check("sweep_ready", 64'(rdy), 64'd4);
         acc = cyc;
         @(posedge clk); #1;
         sw_valid = 1'b0;
         got = 4'h0;
         for (int k = 0; k < 100 && got != 4'hF; k++) begin
            @(negedge clk);
            for (int g = 0; g < 4; g++) begin
               if (sw_done[g] && !got[g]) begin
                  got[g] = 1'b1;
                  sb_check(g + 1, "sweep", sw_hi[g], sw_lo[g]);
                  if (!o[0] || mul_lat(o, 0) >= 0)
                     check("sweep_latency", 64'(cyc - acc),
                           64'(((g < 2) ? 16 : 32) / ((g % 2 == 0) ? 2 : 4) + 2));
               end
            end
         end
         for (int g = 0; g < 4; g++) begin
            if (!got[g]) begin
               fail("sweep_done_timeout");
               sb_drop(g + 1);
            end
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      cnt = 0;
      for (int g = 0; g < 4; g++) if (sw_busy[g] || sw_rd[g] != 0) cnt++;
      check("sweep_idle_at_end", 64'(cnt), 64'd0);

      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
